// File: rtl/font_pkg.sv
// -----------------------------------------------------------------------------
// font_pkg
// Shared constants and types for the glyph fetch scheduler and its users.
//   GLYPH_ROWS  : rows per glyph (one ROM byte per row)
//   CODE_W      : character code width (ASCII[6:0])
//   ROM_ADDR_W  : font_rom address width, {code, row}
//   ROM_DATA_W  : font_rom data width
//   glyph_state_t : scheduler FSM state
// -----------------------------------------------------------------------------
package font_pkg;

    localparam int GLYPH_ROWS = 16;
    localparam int ROW_W      = 4;
    localparam int CODE_W     = 7;
    localparam int ROM_ADDR_W = 11;
    localparam int ROM_DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } glyph_state_t;

    // ROM address of one glyph row: character code in the upper bits, row below.
    function automatic logic [ROM_ADDR_W-1:0] glyph_addr(
        input logic [CODE_W-1:0] code_v,
        input logic [ROW_W-1:0]  row_v
    );
        return {code_v, row_v};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request at or after the
// pointer, wrapping modulo N_REQ.
//   req_i     : per-requester request levels
//   ptr_i     : highest-priority index for this pick (always < N_REQ)
//   win_oh_o  : one-hot winner (all zero when nothing requests)
//   win_idx_o : binary index of the winner
//   win_vld_o : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int OWNER_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]   req_i,
    input  logic [OWNER_W-1:0] ptr_i,
    output logic [N_REQ-1:0]   win_oh_o,
    output logic [OWNER_W-1:0] win_idx_o,
    output logic               win_vld_o
);

    // Scan from the pointer position, stopping at the first request found.
    always_comb begin : arb_scan
        int  j;
        logic found_s;
        win_oh_o  = '0;
        win_idx_o = '0;
        found_s   = 1'b0;
        j         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(ptr_i) + i) % N_REQ;
            if (!found_s && req_i[j]) begin
                found_s     = 1'b1;
                win_idx_o   = OWNER_W'(j);
                win_oh_o[j] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        win_vld_o = found_s;
    end

endmodule

// File: rtl/glyph_fetch_sched.sv
// -----------------------------------------------------------------------------
// glyph_fetch_sched
// Shares one font_rom among N_REQ text/score cells. A waiting cell is granted
// round-robin; its glyph's 16 row bytes are then read out one per clock and
// presented as registered beats tagged with owner and row.
//   Clock_50    : system clock
//   Reset_n     : asynchronous active-low reset
//   frame_start : 1-cycle pulse, aborts any burst (highest priority)
//   req / code  : per-cell request level and 7-bit character code
//   gnt         : one-hot 1-cycle grant pulse
//   rom_addr    : to font_rom, {code_q, row} during a burst, else 0
//   rom_data    : from font_rom, combinational from rom_addr
//   bvalid/bdata/brow/bowner/bdone : registered beat stream, bdone on row 15
//   busy        : burst in progress
// -----------------------------------------------------------------------------
module glyph_fetch_sched
    import font_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int OWNER_W = $clog2(N_REQ)
) (
    input  logic                    Clock_50,
    input  logic                    Reset_n,
    input  logic                    frame_start,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*CODE_W-1:0] code,
    output logic [N_REQ-1:0]        gnt,
    output logic [ROM_ADDR_W-1:0]   rom_addr,
    input  logic [ROM_DATA_W-1:0]   rom_data,
    output logic                    bvalid,
    output logic [ROM_DATA_W-1:0]   bdata,
    output logic [ROW_W-1:0]        brow,
    output logic [OWNER_W-1:0]      bowner,
    output logic                    bdone,
    output logic                    busy
);

    glyph_state_t          state_q;
    logic [ROW_W-1:0]      row_q;
    logic [CODE_W-1:0]     code_q;
    logic [OWNER_W-1:0]    owner_q;
    logic [OWNER_W-1:0]    ptr_q;
    logic [OWNER_W-1:0]    ptr_d;
    logic [N_REQ-1:0]      gnt_q;
    logic                  bvalid_q;
    logic [ROM_DATA_W-1:0] bdata_q;
    logic [ROW_W-1:0]      brow_q;
    logic [OWNER_W-1:0]    bowner_q;
    logic                  bdone_q;

    logic [N_REQ-1:0]      win_oh_s;
    logic [OWNER_W-1:0]    win_idx_s;
    logic                  win_vld_s;
    logic [CODE_W-1:0]     code_sel_s;

    rr_arbiter #(
        .N_REQ   (N_REQ),
        .OWNER_W (OWNER_W)
    ) u_rr_arbiter (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .win_oh_o  (win_oh_s),
        .win_idx_o (win_idx_s),
        .win_vld_o (win_vld_s)
    );

    // Next pointer sits just past the winner; explicit wrap keeps it < N_REQ
    // for non-power-of-two N_REQ. Also selects the winner's character code.
    always_comb begin
        ptr_d      = '0;
        code_sel_s = code[int'(win_idx_s)*CODE_W +: CODE_W];
        if (int'(win_idx_s) == N_REQ - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = win_idx_s + OWNER_W'(1);
        end
    end

    // ROM address is driven from registers only, and parked at 0 when idle.
    always_comb begin
        rom_addr = '0;
        case (state_q)
            BURST:   rom_addr = glyph_addr(code_q, row_q);
            IDLE:    rom_addr = '0;
            default: rom_addr = '0;
        endcase
    end

    // Scheduler FSM with registered grant and beat outputs.
    always_ff @(posedge Clock_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            code_q   <= '0;
            owner_q  <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            bvalid_q <= 1'b0;
            bdata_q  <= '0;
            brow_q   <= '0;
            bowner_q <= '0;
            bdone_q  <= 1'b0;
        end else if (frame_start) begin
            // Abort: no grant this edge and the round-robin pointer is kept.
            state_q  <= IDLE;
            row_q    <= '0;
            gnt_q    <= '0;
            bvalid_q <= 1'b0;
            bdone_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bvalid_q <= 1'b0;
                    bdone_q  <= 1'b0;
                    row_q    <= '0;
                    if (win_vld_s) begin
                        state_q <= BURST;
                        owner_q <= win_idx_s;
                        code_q  <= code_sel_s;
                        ptr_q   <= ptr_d;
                        gnt_q   <= win_oh_s;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                BURST: begin
                    gnt_q    <= '0;
                    bdata_q  <= rom_data;
                    brow_q   <= row_q;
                    bowner_q <= owner_q;
                    bvalid_q <= 1'b1;
                    // Wraps 15 -> 0 exactly when the burst ends.
                    row_q    <= row_q + ROW_W'(1);
                    if (row_q == ROW_W'(GLYPH_ROWS - 1)) begin
                        bdone_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        bdone_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    row_q    <= '0;
                    gnt_q    <= '0;
                    bvalid_q <= 1'b0;
                    bdone_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign bvalid = bvalid_q;
    assign bdata  = bdata_q;
    assign brow   = brow_q;
    assign bowner = bowner_q;
    assign bdone  = bdone_q;
    assign busy   = (state_q == BURST);

endmodule

// File: tb/tb_glyph_fetch_sched.sv
// -----------------------------------------------------------------------------
// tb_glyph_fetch_sched
// Scoreboard bench: the stimulus pushes expected grants and beats into queues,
// an independent monitor pops and compares whenever the DUT presents them.
// -----------------------------------------------------------------------------
module tb_glyph_fetch_sched;
    import font_pkg::*;

    localparam int N  = 4;
    localparam int OW = 2;

    logic            Clock_50    = 1'b0;
    logic            Reset_n     = 1'b0;
    logic            frame_start = 1'b0;
    logic [N-1:0]    req         = '0;
    logic [N*7-1:0]  code        = '0;
    logic [N-1:0]    gnt;
    logic [10:0]     rom_addr;
    logic [7:0]      rom_data;
    logic            bvalid;
    logic [7:0]      bdata;
    logic [3:0]      brow;
    logic [OW-1:0]   bowner;
    logic            bdone;
    logic            busy;

    typedef struct packed {
        logic [7:0]    data;
        logic [3:0]    row;
        logic [OW-1:0] owner;
        logic          done;
    } beat_t;

    beat_t      exp_beats[$];
    logic [3:0] exp_gnts[$];

    int checks       = 0;
    int errors       = 0;
    int cyc          = 0;
    int gnt_seen     = 0;
    int last_gnt_cyc = -1;
    bit rr_chk       = 1'b0;

    glyph_fetch_sched #(.N_REQ(N), .OWNER_W(OW)) dut (
        .Clock_50    (Clock_50),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .req         (req),
        .code        (code),
        .gnt         (gnt),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .bvalid      (bvalid),
        .bdata       (bdata),
        .brow        (brow),
        .bowner      (bowner),
        .bdone       (bdone),
        .busy        (busy)
    );

    // Font ROM stand-in: arbitrary but address-dependent contents.
    function automatic logic [7:0] rom_f(input logic [10:0] a);
        return a[7:0] ^ {1'b0, a[10:4]} ^ 8'hA5;
    endfunction

    assign rom_data = rom_f(rom_addr);

    initial begin
        forever #5 Clock_50 = ~Clock_50;
    end

    initial begin
        forever begin
            @(posedge Clock_50);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_burst(input int owner, input logic [6:0] c, input int nbeats);
        beat_t b;
        logic [3:0] one_hot;
        one_hot = 4'b0001 << owner;
        exp_gnts.push_back(one_hot);
        for (int r = 0; r < nbeats; r++) begin
            b.row   = 4'(r);
            b.data  = rom_f({c, 4'(r)});
            b.owner = OW'(owner);
            b.done  = (r == 15);
            exp_beats.push_back(b);
        end
    endtask

    task automatic wait_gnts(input int target);
        int i;
        i = 0;
        while (gnt_seen < target && i < 400) begin
            @(negedge Clock_50);
            #1;
            i++;
        end
        check("gnt_wait", 32'(gnt_seen >= target), 32'd1);
    endtask

    task automatic wait_beat(input logic [3:0] r);
        int i;
        i = 0;
        while (!(bvalid === 1'b1 && brow === r) && i < 100) begin
            @(negedge Clock_50);
            #1;
            i++;
        end
        check("beat_wait", 32'(bvalid === 1'b1 && brow === r), 32'd1);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_beats.size() > 0 && i < 100) begin
            @(negedge Clock_50);
            #1;
            i++;
        end
        check("drain", 32'(exp_beats.size()), 32'd0);
        repeat (2) @(negedge Clock_50);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},      32'(gnt),      32'd0);
        check({tag, "_bvalid"},   32'(bvalid),   32'd0);
        check({tag, "_bdone"},    32'(bdone),    32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_bdata"},    32'(bdata),    32'd0);
        check({tag, "_brow"},     32'(brow),     32'd0);
        check({tag, "_bowner"},   32'(bowner),   32'd0);
    endtask

    // Monitor: compares every presented grant and beat against the queues.
    initial begin
        beat_t e;
        forever begin
            @(negedge Clock_50);
            if (gnt !== 4'b0000) begin
                gnt_seen = gnt_seen + 1;
                if (exp_gnts.size() == 0) begin
                    check("gnt_unexpected", 32'(gnt), 32'd0);
                end else begin
                    check("gnt", 32'(gnt), 32'(exp_gnts.pop_front()));
                end
                if (rr_chk && last_gnt_cyc >= 0) begin
                    check("gnt_interval", 32'(cyc - last_gnt_cyc), 32'd17);
                end
                last_gnt_cyc = cyc;
            end
            if (bvalid === 1'b1) begin
                if (exp_beats.size() == 0) begin
                    check("beat_unexpected", 32'(bvalid), 32'd0);
                end else begin
                    e = exp_beats.pop_front();
                    check("bdata",  32'(bdata),  32'(e.data));
                    check("brow",   32'(brow),   32'(e.row));
                    check("bowner", 32'(bowner), 32'(e.owner));
                    check("bdone",  32'(bdone),  32'(e.done));
                end
            end else if (bdone !== 1'b0) begin
                check("bdone_no_beat", 32'(bdone), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset held with all cells requesting.
        req  = 4'b1111;
        code = {7'h3A, 7'h32, 7'h31, 7'h30};
        repeat (3) @(negedge Clock_50);
        #1;
        check_all_zero("reset");

        // Round-robin: 0,1,2,3,0 with 17 cycles between grants.
        push_burst(0, 7'h30, 16);
        push_burst(1, 7'h31, 16);
        push_burst(2, 7'h32, 16);
        push_burst(3, 7'h3A, 16);
        push_burst(0, 7'h30, 16);
        rr_chk       = 1'b1;
        last_gnt_cyc = -1;
        Reset_n      = 1'b1;
        @(negedge Clock_50);
        #1;
        check("gnt_after_reset", 32'(gnt), 32'h1);
        wait_gnts(5);
        req    = 4'b0000;
        rr_chk = 1'b0;
        drain();

        // Single burst for cell 2, code 0x35, with ROM address sweep.
        code[14 +: 7] = 7'h35;
        req = 4'b0100;
        push_burst(2, 7'h35, 16);
        wait_gnts(gnt_seen + 1);
        req = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            check("rom_addr", 32'(rom_addr), 32'(11'h350 + 11'(k)));
            @(negedge Clock_50);
            #1;
        end
        drain();

        // Cell 1 drops its request mid-burst; all 16 beats still arrive.
        code[7 +: 7] = 7'h4C;
        req = 4'b0010;
        push_burst(1, 7'h4C, 16);
        wait_gnts(gnt_seen + 1);
        repeat (3) @(negedge Clock_50);
        #1;
        req = 4'b0000;
        drain();

        // frame_start at beat 5 of a cell-2 burst.
        code[14 +: 7] = 7'h12;
        req = 4'b0100;
        push_burst(2, 7'h12, 6);
        wait_gnts(gnt_seen + 1);
        req = 4'b0000;
        wait_beat(4'd5);
        frame_start = 1'b1;
        @(negedge Clock_50);
        #1;
        frame_start = 1'b0;
        check("fs_bvalid",   32'(bvalid),   32'd0);
        check("fs_busy",     32'(busy),     32'd0);
        check("fs_bdone",    32'(bdone),    32'd0);
        check("fs_rom_addr", 32'(rom_addr), 32'd0);
        repeat (3) @(negedge Clock_50);
        #1;
        check("fs_leftover", 32'(exp_beats.size()), 32'd0);

        // Pointer kept at 3 after the abort, so cell 3 wins over 0 and 1.
        code[21 +: 7] = 7'h7F;
        req = 4'b1011;
        push_burst(3, 7'h7F, 16);
        wait_gnts(gnt_seen + 1);
        req = 4'b0000;
        drain();

        // Async reset while row register is 9 (beat 8 on the outputs).
        code[0 +: 7] = 7'h01;
        req = 4'b0001;
        push_burst(0, 7'h01, 9);
        wait_gnts(gnt_seen + 1);
        req = 4'b0000;
        wait_beat(4'd8);
        Reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(negedge Clock_50);
        #1;
        Reset_n = 1'b1;
        repeat (20) @(negedge Clock_50);
        #1;
        check("end_beats_left", 32'(exp_beats.size()), 32'd0);
        check("end_gnts_left",  32'(exp_gnts.size()),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
